// File: rtl/gol_gen_scheduler_pkg.sv
// Shared definitions for the Game-of-Life generation scheduler: state encoding,
// write-back offset and the grid-height legality check.
package gol_gen_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_TICK,
      ST_READ,
      ST_DRAIN,
      ST_FLIP
   } state_t;

   // First write-back happens this many cycles after the first read of a generation.
   localparam int WR_START     = 4;
   localparam int DRAIN_CYCLES = 2;

   function automatic bit rows_legal(input int rows);
      return rows >= 3;
   endfunction

endpackage

// File: rtl/gol_row_addr_gen.sv
// Modulo-ROWS read and write row address counters; the read counter starts at
// ROWS-1 so the window is primed with the wrap-around row above row 0.
module gol_row_addr_gen #(
   parameter int ROWS   = 16,
   parameter int ROW_AW = $clog2(ROWS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_rd_adv,
   input  logic              i_wr_adv,
   output logic [ROW_AW-1:0] o_rd_addr,
   output logic [ROW_AW-1:0] o_wr_addr
);

   localparam logic [ROW_AW-1:0] LAST = ROW_AW'(ROWS - 1);

   logic [ROW_AW-1:0] r_rd;
   logic [ROW_AW-1:0] r_wr;

   function automatic logic [ROW_AW-1:0] wrap_inc(input logic [ROW_AW-1:0] a);
      return (a == LAST) ? '0 : a + ROW_AW'(1);
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd <= LAST;
         r_wr <= '0;
      end else if (i_clear) begin
         r_rd <= LAST;
         r_wr <= '0;
      end else begin
         if (i_rd_adv) r_rd <= wrap_inc(r_rd);
         if (i_wr_adv) r_wr <= wrap_inc(r_wr);
      end
   end

   // Addresses read as zero whenever their strobe is low.
   assign o_rd_addr = i_rd_adv ? r_rd : '0;
   assign o_wr_addr = i_wr_adv ? r_wr : '0;

endmodule

// File: rtl/gol_gen_scheduler.sv
// Sequences one Game-of-Life generation: row reads, window shifts, write-backs
// and the ping-pong bank flip, with run/step/stop control and tick pacing.
module gol_gen_scheduler
   import gol_gen_scheduler_pkg::*;
#(
   parameter int ROWS   = 16,
   parameter int ROW_AW = $clog2(ROWS),
   parameter int GEN_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_step,
   input  logic              i_stop,
   input  logic              i_tick,
   input  logic [GEN_W-1:0]  i_gen_limit,
   output logic              o_rd_en,
   output logic [ROW_AW-1:0] o_rd_addr,
   output logic              o_win_shift,
   output logic              o_wr_en,
   output logic [ROW_AW-1:0] o_wr_addr,
   output logic              o_cur_bank,
   output logic              o_busy,
   output logic              o_running,
   output logic              o_gen_done,
   output logic [GEN_W-1:0]  o_gen_count
);

   if (!rows_legal(ROWS)) begin : g_rows_check
      $error("gol_gen_scheduler: ROWS must be >= 3");
   end

   localparam int              CNT_W      = $clog2(ROWS + 2);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(ROWS + 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_FIRST   = CNT_W'(WR_START);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_win_shift;
   logic               r_cur_bank;
   logic               r_running;
   logic               r_stop_seen;
   logic [GEN_W-1:0]   r_gen_count;
   logic [GEN_W-1:0]   r_run_cnt;
   logic [GEN_W-1:0]   w_run_next;
   logic               w_flip_stop;
   logic               w_rd_en;
   logic               w_wr_en;

   assign w_run_next = r_run_cnt + GEN_W'(1);
   // A stop arriving in the FLIP cycle itself still ends the run.
   assign w_flip_stop = !r_running || r_stop_seen || i_stop ||
                        ((i_gen_limit != '0) && (w_run_next == i_gen_limit));

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!i_stop) begin
               if (i_step)       w_next = ST_READ;
               else if (i_start) w_next = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (i_stop)      w_next = ST_IDLE;
            else if (i_tick) w_next = ST_READ;
         end
         ST_READ:  if (r_cnt == READ_LAST)  w_next = ST_DRAIN;
         ST_DRAIN: if (r_cnt == DRAIN_LAST) w_next = ST_FLIP;
         ST_FLIP:  w_next = w_flip_stop ? ST_IDLE : ST_WAIT_TICK;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_win_shift <= 1'b0;
         r_cur_bank  <= 1'b0;
         r_running   <= 1'b0;
         r_stop_seen <= 1'b0;
         r_gen_count <= '0;
         r_run_cnt   <= '0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
         r_win_shift <= w_rd_en;
         case (r_state)
            ST_IDLE: begin
               if (!i_stop && !i_step && i_start) begin
                  r_running <= 1'b1;
                  r_run_cnt <= '0;
               end
            end
            ST_WAIT_TICK: if (i_stop) r_running <= 1'b0;
            ST_READ, ST_DRAIN: if (i_stop) r_stop_seen <= 1'b1;
            ST_FLIP: begin
               r_cur_bank  <= ~r_cur_bank;
               r_gen_count <= r_gen_count + GEN_W'(1);
               r_stop_seen <= 1'b0;
               if (r_running)   r_run_cnt <= w_run_next;
               if (w_flip_stop) r_running <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign w_rd_en = (r_state == ST_READ);
   assign w_wr_en = ((r_state == ST_READ) && (r_cnt >= WR_FIRST)) || (r_state == ST_DRAIN);

   gol_row_addr_gen #(
      .ROWS   (ROWS),
      .ROW_AW (ROW_AW)
   ) u_addr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (!(w_rd_en || (r_state == ST_DRAIN))),
      .i_rd_adv  (w_rd_en),
      .i_wr_adv  (w_wr_en),
      .o_rd_addr (o_rd_addr),
      .o_wr_addr (o_wr_addr)
   );

   assign o_rd_en     = w_rd_en;
   assign o_win_shift = r_win_shift;
   assign o_wr_en     = w_wr_en;
   assign o_cur_bank  = r_cur_bank;
   assign o_busy      = (r_state == ST_READ) || (r_state == ST_DRAIN) || (r_state == ST_FLIP);
   assign o_running   = r_running;
   assign o_gen_done  = (r_state == ST_FLIP);
   assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Self-checking bench for gol_gen_scheduler: a generation-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_gol_gen_scheduler;

   localparam int ROWS   = 4;
   localparam int ROW_AW = 2;
   localparam int GEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0, step = 1'b0, stop = 1'b0, tick = 1'b0;
   logic [GEN_W-1:0]  gen_limit = '0;
   logic              rd_en, win_shift, wr_en, cur_bank, busy, running, gen_done;
   logic [ROW_AW-1:0] rd_addr, wr_addr;
   logic [GEN_W-1:0]  gen_count;

   gol_gen_scheduler #(.ROWS(ROWS), .ROW_AW(ROW_AW), .GEN_W(GEN_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step(step), .i_stop(stop),
      .i_tick(tick), .i_gen_limit(gen_limit), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
      .o_win_shift(win_shift), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_cur_bank(cur_bank),
      .o_busy(busy), .o_running(running), .o_gen_done(gen_done), .o_gen_count(gen_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model (generation level) ----------------
   int cyc = 0, m_s = 0, m_runs = 0, m_gcount = 0;
   bit m_busy = 0, m_wait = 0, m_running = 0, m_stop = 0, m_bank = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_s = 0; m_runs = 0; m_gcount = 0;
         m_busy = 0; m_wait = 0; m_running = 0; m_stop = 0; m_bank = 0;
      end else begin
         if (m_busy) begin
            if (stop) m_stop = 1;
            if (cyc - m_s == ROWS + 4) begin
               bit fin;
               m_bank   = ~m_bank;
               m_gcount = (m_gcount + 1) % (1 << GEN_W);
               if (m_running) m_runs++;
               fin = !m_running || m_stop || ((gen_limit != 0) && (m_runs == int'(gen_limit)));
               m_busy = 0;
               m_stop = 0;
               if (fin) m_running = 0;
               else     m_wait = 1;
            end
         end else if (m_wait) begin
            if (stop) begin
               m_wait = 0; m_running = 0;
            end else if (tick) begin
               m_wait = 0; m_busy = 1; m_s = cyc + 1;
            end
         end else if (!stop) begin
            if (step) begin
               m_busy = 1; m_s = cyc + 1;
            end else if (start) begin
               m_running = 1; m_runs = 0; m_wait = 1;
            end
         end
         cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 0;
   int n_done = 0, n_wr = 0, n_rd = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         int k;
         bit e_rd, e_sh, e_wr, e_done;
         k      = cyc - m_s;
         e_rd   = m_busy && (k <= ROWS + 1);
         e_sh   = m_busy && (k >= 1) && (k <= ROWS + 2);
         e_wr   = m_busy && (k >= 4) && (k <= ROWS + 3);
         e_done = m_busy && (k == ROWS + 4);
         check("rd_en", rd_en, e_rd);
         if (e_rd) check("rd_addr", rd_addr, (k + ROWS - 1) % ROWS);
         check("win_shift", win_shift, e_sh);
         check("wr_en", wr_en, e_wr);
         if (e_wr) check("wr_addr", wr_addr, k - 4);
         check("gen_done", gen_done, e_done);
         check("busy", busy, m_busy);
         check("running", running, m_running);
         check("cur_bank", cur_bank, m_bank);
         check("gen_count", gen_count, m_gcount);
         n_done += gen_done;
         n_wr   += wr_en;
         n_rd   += rd_en;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; start = 0; step = 0; stop = 0; tick = 0; gen_limit = '0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_step();
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int waited);
      waited = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (gen_done) begin
            waited = i;
            break;
         end
      end
      if (waited == 0) check({name, "_timeout"}, 0, 1);
   endtask

   int exp_rd[6] = '{3, 0, 1, 2, 3, 0};

   initial begin
      int w, d0, r0, w0;
      do_reset();
      chk_en = 1;
      check("rst_busy", busy, 0);
      check("rst_gen_count", gen_count, 0);

      // T1: single step, literal timeline from S
      pulse_step();
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         check("t1_rd_en", rd_en, (k <= 5) ? 1 : 0);
         if (k <= 5) check("t1_rd_addr", rd_addr, exp_rd[k]);
         check("t1_win_shift", win_shift, (k >= 1 && k <= 6) ? 1 : 0);
         check("t1_wr_en", wr_en, (k >= 4 && k <= 7) ? 1 : 0);
         if (k >= 4 && k <= 7) check("t1_wr_addr", wr_addr, k - 4);
         check("t1_gen_done", gen_done, (k == 8) ? 1 : 0);
         check("t1_busy", busy, 1);
      end
      @(negedge clk);
      check("t1_busy_end", busy, 0);
      check("t1_cur_bank", cur_bank, 1);
      check("t1_gen_count", gen_count, 1);
      check("t1_running", running, 0);

      // T2: tick held high, gen_limit=3
      do_reset();
      gen_limit = 16'd3; tick = 1'b1;
      d0 = n_done;
      pulse_start();
      wait_done("t2_g1", 40, w);
      wait_done("t2_g2", 40, w);
      check("t2_period2", w, 10);
      wait_done("t2_g3", 40, w);
      check("t2_period3", w, 10);
      @(negedge clk);
      check("t2_running", running, 0);
      check("t2_gen_count", gen_count, 3);
      check("t2_cur_bank", cur_bank, 1);
      repeat (30) @(negedge clk);
      check("t2_done_pulses", n_done - d0, 3);
      tick = 1'b0;

      // T3: tick every 50 cycles, gen_limit=2
      do_reset();
      gen_limit = 16'd2;
      pulse_start();
      for (int g = 0; g < 2; g++) begin
         r0 = n_rd;
         repeat (50) @(negedge clk);
         check("t3_no_rd_in_wait", n_rd - r0, 0);
         tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         check("t3_read_after_tick", rd_en, 1);
         check("t3_first_addr", rd_addr, 3);
         wait_done("t3_gen", 20, w);
      end
      @(negedge clk);
      check("t3_running", running, 0);
      check("t3_gen_count", gen_count, 2);

      // T4a: stop at S+2 of a run generation
      do_reset();
      pulse_start();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      check("t4_read_start", rd_en, 1);
      w0 = n_wr;
      @(negedge clk);
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      wait_done("t4_gen", 20, w);
      check("t4_writes", n_wr - w0, 4);
      @(negedge clk);
      check("t4_running", running, 0);
      r0 = n_rd;
      tick = 1'b1;
      repeat (20) @(negedge clk);
      tick = 1'b0;
      check("t4_idle_no_rd", n_rd - r0, 0);

      // T4b: stop and tick together in WAIT_TICK
      do_reset();
      pulse_start();
      r0 = n_rd;
      @(negedge clk); stop = 1'b1; tick = 1'b1;
      @(negedge clk); stop = 1'b0; tick = 1'b0;
      check("t4b_running", running, 0);
      repeat (5) @(negedge clk);
      check("t4b_no_rd", n_rd - r0, 0);

      // T5a: start+step together
      do_reset();
      d0 = n_done;
      @(negedge clk); start = 1'b1; step = 1'b1;
      @(negedge clk); start = 1'b0; step = 1'b0;
      check("t5_running", running, 0);
      wait_done("t5_gen", 20, w);
      repeat (30) @(negedge clk);
      check("t5_single_gen", n_done - d0, 1);
      check("t5_running_end", running, 0);

      // T5b: step while busy is ignored
      do_reset();
      d0 = n_done;
      pulse_step();
      repeat (3) @(negedge clk);
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      wait_done("t5b_gen", 20, w);
      repeat (20) @(negedge clk);
      check("t5b_single_gen", n_done - d0, 1);
      check("t5b_busy", busy, 0);

      // T6: asynchronous reset at S+5 of a second generation
      do_reset();
      pulse_step();
      wait_done("t6_g1", 20, w);
      pulse_step();
      repeat (4) @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_rd_en", rd_en, 0);
      check("t6_rst_wr_en", wr_en, 0);
      check("t6_rst_win_shift", win_shift, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_cur_bank", cur_bank, 0);
      check("t6_rst_gen_count", gen_count, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      pulse_step();
      check("t6_clean_start", rd_addr, 3);
      wait_done("t6_g2", 20, w);
      @(negedge clk);
      check("t6_gen_count", gen_count, 1);
      check("t6_cur_bank", cur_bank, 1);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gol_gen_scheduler.md
Name: gol_gen_scheduler

Overview:
- Sequences one Game-of-Life generation over a toroidal grid of ROWS rows.
- The grid is held in a ping-pong row memory with two banks; each word is one full row of COLS cells.
- The scheduler issues row reads from the source bank and drives shift strobes into the row-evaluator datapath. That datapath holds a 3-row window and, per cell, a neighbour adder feeding the sum-to-signal decoder.
- The scheduler issues write-backs of computed rows to the destination bank, then flips banks. It also provides run/step/stop control, tick pacing and a generation counter.

Parameters:
ROWS, 16, grid height in rows; legal range ROWS >= 3
ROW_AW, $clog2(ROWS), row address width
GEN_W, 16, width of the generation counter and of gen_limit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  enter run mode; generations repeat, paced by tick
step  in  1  run exactly one generation without waiting for tick
stop  in  1  leave run mode once the current generation completes
tick  in  1  pacing pulse; a run-mode generation begins only in a cycle with tick=1
gen_limit  in  GEN_W  in run mode, stop automatically after this many generations; 0 = unlimited
rd_en  out  1  memory read strobe (synchronous read, data valid next cycle)
rd_addr  out  ROW_AW  row address being read
win_shift  out  1  datapath shifts returned row data into its 3-row window
wr_en  out  1  write the evaluator result row
wr_addr  out  ROW_AW  row address being written
cur_bank  out  1  bank holding the valid current generation; reads use cur_bank, writes use ~cur_bank
busy  out  1  high from the first read of a generation through the bank flip; host must not write memory while high
running  out  1  run mode active
gen_done  out  1  one-cycle pulse in the bank-flip cycle
gen_count  out  GEN_W  generations completed since reset; wraps at 2^GEN_W

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; every output 0; cur_bank=0; gen_count=0; internal run counter 0. Reset mid-generation abandons it; the destination bank contents are then don't-care.
- States: IDLE, WAIT_TICK, READ, DRAIN, FLIP.
- IDLE:
  - step=1 -> READ on the next cycle.
  - Otherwise start=1 -> running=1, run counter cleared, -> WAIT_TICK.
  - Command priority in the same cycle: stop > step > start. stop in IDLE has no effect.
- WAIT_TICK:
  - tick=1 -> READ.
  - stop=1 -> running=0, -> IDLE. stop has priority over tick.
- READ: lasts ROWS+2 cycles, k = 0..ROWS+1 counted from the first READ cycle S.
  - In cycle S+k: rd_en=1, rd_addr = (k-1) mod ROWS, giving the order ROWS-1, 0, 1, ..., ROWS-1, 0.
- Window strobe: win_shift=1 in cycles S+1 .. S+ROWS+2, i.e. one cycle after each read.
- Write-back:
  - wr_en=1 in cycles S+4 .. S+ROWS+3, with wr_addr = 0 .. ROWS-1 in order.
  - This gives one cycle of evaluator settle after the third shift.
- DRAIN: covers cycles S+ROWS+2 and S+ROWS+3, in which the remaining shift and writes complete.
- FLIP (cycle S+ROWS+4):
  - cur_bank toggles, gen_done=1, gen_count increments.
  - If running, the run counter increments.
  - Next state:
    - -> IDLE, with running=0, if not running, or stop was seen during the generation, or (gen_limit != 0 and run counter == gen_limit).
    - -> WAIT_TICK otherwise.
- busy: high in cycles S .. S+ROWS+4 inclusive.
- Generation period when tick is held high: ROWS+6 cycles (FLIP, then one WAIT_TICK cycle, then READ).
- A generation is never aborted by stop. stop is latched while busy and takes effect at FLIP, so banks are always consistent.
- step while running or busy is ignored. start while running is ignored.
- tick is ignored outside WAIT_TICK.
- gen_limit is sampled continuously; changing it mid-run affects only the comparison made at FLIP.

Decomposition:
- Shared package: state encoding constants; the ROWS >= 3 legality check.
- Sub-module gol_row_addr_gen: modulo-ROWS read and write address counters with wrap, including the k-1 start offset.
- The FSM, command latching and counters stay in the top module.

Test Plan:
- ROWS=4, pulse step in IDLE, first READ cycle S -> rd_addr 3,0,1,2,3,0 on S..S+5; win_shift on S+1..S+6; wr_addr 0,1,2,3 on S+4..S+7; gen_done at S+8; cur_bank 0->1; gen_count=1; busy S..S+8.
- start with tick held high, gen_limit=3 -> exactly three gen_done pulses, 10 cycles apart; running falls at the third FLIP; gen_count=3; cur_bank=1.
- Run mode with tick pulsed every 50 cycles -> each READ begins the cycle after a tick; no rd_en while in WAIT_TICK.
- stop asserted at S+2 of a run generation -> all 4 writes complete, gen_done still fires, then IDLE with running=0; stop+tick in the same WAIT_TICK cycle -> IDLE with no READ.
- start and step together in IDLE -> single generation only, running stays 0; step while busy -> ignored, no second generation.
- rst_n low at S+5 -> all outputs 0 immediately (asynchronously), cur_bank=0, gen_count=0; a subsequent step runs a clean generation from S'.
